// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding, frame geometry and the
// odd-parity helper used by both the receiver and its bench.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_DATA_BITS  = 8;

   // Parity bit a device sends so that data plus parity holds an odd number of ones.
   function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] b);
      return ~(^b);
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous show-ahead FIFO for received bytes; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ps2_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CW-1:0]    count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_q];
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_q <= rd_q + AW'(1);
         end
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/ps2_rx_sequencer.sv
// PS/2 host receiver: pin synchronisers, frame FSM with framing/parity/timeout
// checks, and a byte FIFO. Optional clock inhibit under `PS2_INHIBIT_EN.
module ps2_rx_sequencer
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       ps2_clk_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       err_frame,
   output logic       err_parity,
   output logic       err_timeout,
   output logic       overflow,
   output logic       busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [SYNC_STAGES-1:0]   clk_sync_q;
   logic [SYNC_STAGES-1:0]   dat_sync_q;
   logic                     clk_prev_q;
   logic                     fall_q;
   logic                     bit_q;
   logic                     fall_eff;

   ps2_state_e               state_q;
   logic [2:0]               bitcnt_q;
   logic [PS2_DATA_BITS-1:0] shreg_q;
   logic                     par_ok_q;
   logic [TW-1:0]            tmo_q;
   logic                     tmo_hit;
   logic                     err_frame_q;
   logic                     err_parity_q;
   logic                     err_timeout_q;
   logic                     overflow_q;

   logic                     push_req;
   logic                     fifo_pop;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [CW-1:0]            fifo_count;

   // Sync flops reset high so a pin idling high never looks like a fall out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
         fall_q     <= 1'b0;
         bit_q      <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
         clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
         fall_q     <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
         bit_q      <= dat_sync_q[SYNC_STAGES-1];
      end
   end

`ifdef PS2_INHIBIT_EN
   localparam int HW = $clog2(SYNC_STAGES + 2);

   logic          oe_q;
   logic [HW-1:0] hold_q;

   // After release the synchronisers still carry the held-low clock; mask that tail.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oe_q   <= 1'b0;
         hold_q <= '0;
      end else if (oe_q) begin
         if (fifo_count < CW'(FIFO_DEPTH - 1)) begin
            oe_q   <= 1'b0;
            hold_q <= HW'(SYNC_STAGES + 1);
         end
      end else if ((state_q == IDLE) && (fifo_count >= CW'(FIFO_DEPTH - 1))) begin
         oe_q <= 1'b1;
      end else if (hold_q != '0) begin
         hold_q <= hold_q - HW'(1);
      end
   end

   assign fall_eff   = fall_q & ~oe_q & (hold_q == '0);
   assign ps2_clk_oe = oe_q;
`else
   logic unused_count;

   assign unused_count = ^fifo_count;
   assign fall_eff     = fall_q;
   assign ps2_clk_oe   = 1'b0;
`endif

   assign tmo_hit  = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign push_req = (state_q == STOP) & fall_eff & bit_q & par_ok_q & ~tmo_hit;
   assign fifo_pop = ~fifo_empty & rx_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         bitcnt_q      <= '0;
         shreg_q       <= '0;
         par_ok_q      <= 1'b0;
         tmo_q         <= '0;
         err_frame_q   <= 1'b0;
         err_parity_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         err_frame_q   <= 1'b0;
         err_parity_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         overflow_q    <= push_req & fifo_full & ~fifo_pop;
         if (state_q == IDLE) begin
            tmo_q <= '0;
            if (fall_eff) begin
               if (bit_q) begin
                  err_frame_q <= 1'b1;
               end else begin
                  state_q  <= DATA;
                  bitcnt_q <= '0;
               end
            end
         end else if (tmo_hit) begin
            // Timeout wins over a coincident fall; the partial byte is dropped.
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
            tmo_q         <= '0;
         end else if (fall_eff) begin
            tmo_q <= '0;
            case (state_q)
               DATA: begin
                  shreg_q  <= {bit_q, shreg_q[PS2_DATA_BITS-1:1]};
                  bitcnt_q <= bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     state_q <= PARITY;
                  end
               end
               PARITY: begin
                  par_ok_q <= (^shreg_q) ^ bit_q;
                  state_q  <= STOP;
               end
               default: begin
                  state_q <= IDLE;
                  if (!bit_q) begin
                     err_frame_q <= 1'b1;
                  end else if (!par_ok_q) begin
                     err_parity_q <= 1'b1;
                  end
               end
            endcase
         end else begin
            tmo_q <= tmo_q + TW'(1);
         end
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PS2_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_req),
      .din_i   (shreg_q),
      .pop_i   (fifo_pop),
      .dout_o  (rx_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rx_valid    = ~fifo_empty;
   assign err_frame   = err_frame_q;
   assign err_parity  = err_parity_q;
   assign err_timeout = err_timeout_q;
   assign overflow    = overflow_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_sequencer.sv
// Bench for ps2_rx_sequencer: drives PS/2 frames on the pins and checks popped
// bytes against an expected queue plus error-pulse counts. Honours PS2_INHIBIT_EN.
module tb_ps2_rx_sequencer;
   import ps2_pkg::*;

   localparam int SYNC  = 2;
   localparam int TMO   = 2000;
   localparam int DEPTH = 4;
   localparam int CLK_P = 10;
   localparam int HALF  = 200;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_dat;
   logic       ps2_clk_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       err_frame;
   logic       err_parity;
   logic       err_timeout;
   logic       overflow;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int n_frame = 0;
   int n_parity = 0;
   int n_timeout = 0;
   int n_ovf = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   always #(CLK_P/2) clk = ~clk;

   ps2_rx_sequencer #(
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TMO),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_clk     (ps2_clk),
      .ps2_dat     (ps2_dat),
      .ps2_clk_oe  (ps2_clk_oe),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .err_frame   (err_frame),
      .err_parity  (err_parity),
      .err_timeout (err_timeout),
      .overflow    (overflow),
      .busy        (busy)
   );

   // Scoreboard: every handshake pops one expected byte.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (err_frame)   n_frame++;
         if (err_parity)  n_parity++;
         if (err_timeout) n_timeout++;
         if (overflow)    n_ovf++;
         if (rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rx_pop unexpected byte got %02h required none", rx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (rx_data !== mon_exp) begin
                  errors++;
                  $display("FAIL rx_pop data got %02h required %02h", rx_data, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      #(5_000_000);
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic set_ready(input logic v);
      @(posedge clk);
      #2 rx_ready = v;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_dat = b;
      #(HALF);
      ps2_clk = 1'b0;
      #(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int nbits);
      logic [10:0] f;
      f = {stop, ps2_odd_parity(d) ^ par_flip, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_bit(f[i]);
      end
      ps2_dat = 1'b1;
      #(HALF*2);
   endtask

   task automatic wait_drain(output logic ok);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      ok = (exp_q.size() == 0);
   endtask

   task automatic test_reset;
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_dat  = 1'b1;
      rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b required 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %02h required 00", rx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
      checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b required 0", ps2_clk_oe); end
      checks++;
      if ({err_frame, err_parity, err_timeout, overflow} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_err got %b required 0000", {err_frame, err_parity, err_timeout, overflow});
      end
      @(posedge clk);
      #2 reset = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got busy=%b valid=%b required 0 0", busy, rx_valid); end
      checks++; if (n_frame != 0) begin errors++; $display("FAIL post_reset_false_edge got %0d required 0", n_frame); end
   endtask

   task automatic test_single;
      int e0;
      logic ok;
      set_ready(1'b0);
      e0 = n_frame + n_parity + n_timeout + n_ovf;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1, 11);
      @(negedge clk);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b required 1", rx_valid); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %02h required a5", rx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b required 0", busy); end
      checks++; if (n_frame + n_parity + n_timeout + n_ovf != e0) begin errors++; $display("FAIL single_err got %0d required %0d", n_frame + n_parity + n_timeout + n_ovf, e0); end
      set_ready(1'b1);
      wait_drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_drain got %0d left required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back;
      int e0;
      logic ok;
      logic [7:0] v [3];
      v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h01;
      set_ready(1'b1);
      e0 = n_frame + n_parity + n_timeout + n_ovf;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(v[i]);
         send_frame(v[i], 1'b0, 1'b1, 11);
      end
      wait_drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_drain got %0d left required 0", exp_q.size()); end
      checks++; if (n_frame + n_parity + n_timeout + n_ovf != e0) begin errors++; $display("FAIL b2b_err got %0d required %0d", n_frame + n_parity + n_timeout + n_ovf, e0); end
   endtask

   task automatic test_parity;
      int p0, f0;
      set_ready(1'b0);
      p0 = n_parity; f0 = n_frame;
      send_frame(8'h3C, 1'b1, 1'b1, 11);
      @(negedge clk);
      checks++; if (n_parity - p0 != 1) begin errors++; $display("FAIL parity_pulses got %0d required 1", n_parity - p0); end
      checks++; if (n_frame != f0) begin errors++; $display("FAIL parity_frame got %0d required 0", n_frame - f0); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_valid got %b required 0", rx_valid); end
   endtask

   task automatic test_frame;
      int p0, f0;
      logic ok;
      set_ready(1'b0);
      p0 = n_parity; f0 = n_frame;
      send_frame(8'h3C, 1'b0, 1'b0, 11);
      @(negedge clk);
      checks++; if (n_frame - f0 != 1) begin errors++; $display("FAIL frame_pulses got %0d required 1", n_frame - f0); end
      checks++; if (n_parity != p0) begin errors++; $display("FAIL frame_parity got %0d required 0", n_parity - p0); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_valid got %b required 0", rx_valid); end
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b0, 1'b1, 11);
      set_ready(1'b1);
      wait_drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL frame_next_drain got %0d left required 0", exp_q.size()); end
   endtask

   task automatic test_timeout;
      int t0, f0;
      logic ok;
      set_ready(1'b1);
      t0 = n_timeout; f0 = n_frame + n_parity;
      send_frame(8'h5A, 1'b0, 1'b1, 5);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_mid got %b required 1", busy); end
      #((TMO + 10) * CLK_P);
      @(negedge clk);
      checks++; if (n_timeout - t0 != 1) begin errors++; $display("FAIL timeout_pulses got %0d required 1", n_timeout - t0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b required 0", busy); end
      checks++; if (n_frame + n_parity != f0) begin errors++; $display("FAIL timeout_other_err got %0d required 0", n_frame + n_parity - f0); end
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b0, 1'b1, 11);
      wait_drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL timeout_next_drain got %0d left required 0", exp_q.size()); end
   endtask

   task automatic test_overflow;
      int o0;
      logic ok;
      set_ready(1'b0);
      o0 = n_ovf;
`ifdef PS2_INHIBIT_EN
      for (int v = 1; v <= 3; v++) begin
         exp_q.push_back(8'(v));
         send_frame(8'(v), 1'b0, 1'b1, 11);
      end
      repeat (5) @(negedge clk);
      checks++; if (ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL inhibit_set got %b required 1", ps2_clk_oe); end
      checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL inhibit_head got %02h required 01", rx_data); end
      set_ready(1'b1);
      set_ready(1'b0);
      repeat (SYNC + 4) @(negedge clk);
      checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL inhibit_release got %b required 0", ps2_clk_oe); end
`else
      for (int v = 1; v <= DEPTH + 1; v++) begin
         if (v <= DEPTH) exp_q.push_back(8'(v));
         send_frame(8'(v), 1'b0, 1'b1, 11);
      end
      @(negedge clk);
      checks++; if (n_ovf - o0 != 1) begin errors++; $display("FAIL overflow_pulses got %0d required 1", n_ovf - o0); end
      checks++; if (rx_data !== 8'h01 || rx_valid !== 1'b1) begin errors++; $display("FAIL overflow_head got %02h/%b required 01/1", rx_data, rx_valid); end
      checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL overflow_oe got %b required 0", ps2_clk_oe); end
`endif
      set_ready(1'b1);
      wait_drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL overflow_drain got %0d left required 0", exp_q.size()); end
`ifdef PS2_INHIBIT_EN
      checks++; if (n_ovf != o0) begin errors++; $display("FAIL inhibit_overflow got %0d required 0", n_ovf - o0); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_frame();
      test_timeout();
      test_overflow();
      repeat (10) @(negedge clk);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got %0d left required 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
